// File: rtl/counter_wrap_param.sv
// ---------------------------------------------------------------------------
// counter_wrap_param
//
// Bounded up/down counter for calendar-style fields such as seconds, hours or
// day-of-month. The count stays between MIN_VAL and an effective maximum,
// where limit may lower that maximum at run time. When it runs past a bound
// the counter either wraps (SATURATE=0) or holds at the bound (SATURATE=1).
//
// Parameters
//   WIDTH     bit width of value, limit and load_val
//   MIN_VAL   lowest count value, also the reset value
//   MAX_VAL   static upper bound (MIN_VAL < MAX_VAL <= 2^WIDTH-1)
//   SATURATE  0 = wrap at the bounds, 1 = hold at the bounds
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   en          in   enables inc_auto, inc_manual, dec_manual and load
//   limit       in   run-time upper bound, used only if MIN_VAL..MAX_VAL
//   inc_auto    in   cascade increment tick (the only source of carry_out)
//   inc_manual  in   user increment
//   dec_manual  in   user decrement
//   load        in   synchronous load request
//   load_val    in   load data, limited to MIN_VAL..eff_max
//   value       out  registered count
//   carry_out   out  one-cycle pulse: an auto increment wrapped
//   borrow_out  out  one-cycle pulse: a decrement wrapped
//   clamp_evt   out  one-cycle pulse: value was forced down to eff_max
//   at_max      out  combinational: value == eff_max
// ---------------------------------------------------------------------------
module counter_wrap_param #(
    parameter int WIDTH    = 6,
    parameter int MIN_VAL  = 1,
    parameter int MAX_VAL  = 31,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    input  logic             inc_auto,
    input  logic             inc_manual,
    input  logic             dec_manual,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             clamp_evt,
    output logic             at_max
);

    // Stop elaboration on a bound set that cannot be represented.
    if (!(MIN_VAL < MAX_VAL && MAX_VAL <= (2 ** WIDTH) - 1)) begin : g_bad_params
        $error("counter_wrap_param: need MIN_VAL < MAX_VAL <= 2^WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam bit               SAT   = (SATURATE != 0);

    logic [WIDTH-1:0] value_q, value_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             clamp_q, clamp_d;

    logic [WIDTH-1:0] eff_max;
    logic             inc_req;
    logic             above_max;

    // An out-of-range limit (for example 0 before a month is known) falls
    // back to the static maximum so the counter always has a legal ceiling.
    assign eff_max   = (limit >= MIN_V && limit <= MAX_V) ? limit : MAX_V;
    assign inc_req   = inc_auto | inc_manual;
    assign above_max = (value_q > eff_max);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch can be inferred.
        value_d  = value_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        clamp_d  = 1'b0;

        if (en && load) begin
            // A load silently lands inside MIN_VAL..eff_max and raises no pulse.
            if (load_val < MIN_V) begin
                value_d = MIN_V;
            end else if (load_val > eff_max) begin
                value_d = eff_max;
            end else begin
                value_d = load_val;
            end
        end else if (en && dec_manual && inc_req) begin
            // Opposing requests cancel out, but the count must still come
            // back within a freshly lowered limit.
            if (above_max) begin
                value_d = eff_max;
                clamp_d = 1'b1;
            end
        end else if (en && dec_manual) begin
            if (above_max) begin
                value_d = eff_max;
                clamp_d = 1'b1;
            end else if (value_q > MIN_V) begin
                value_d = value_q - ONE;
            end else if (!SAT) begin
                value_d  = eff_max;
                borrow_d = 1'b1;
            end
        end else if (en && inc_req) begin
            if (value_q < eff_max) begin
                value_d = value_q + ONE;
            end else if (!SAT) begin
                // Only the cascade tick ripples on to the next field; a user
                // increment that wraps must not advance the neighbour.
                value_d = MIN_V;
                carry_d = inc_auto;
            end else begin
                value_d = eff_max;
                clamp_d = above_max;
            end
        end else if (above_max) begin
            // The clamp works even when en is low, so a limit change cannot
            // leave the count out of range.
            value_d = eff_max;
            clamp_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q  <= MIN_V;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            clamp_q  <= 1'b0;
        end else begin
            value_q  <= value_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            clamp_q  <= clamp_d;
        end
    end

    assign value      = value_q;
    assign carry_out  = carry_q;
    assign borrow_out = borrow_q;
    assign clamp_evt  = clamp_q;
    assign at_max     = (value_q == eff_max);

endmodule
